clk_divider_multi: RTL and testbench

//   Parametrised multi-channel clock divider; successor to the fixed divide-by-6 converter.

---
 rtl/clk_divider_multi.sv | 141 ++++++++++++++
 tb/tb_clk_divider_multi.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock divider. Each channel produces a registered divided
// clock and a one-cycle tick. Divisor/mode updates are committed only at period boundaries.
module clk_divider_multi #(
    parameter  int NUM_CH      = 2,
    parameter  int CNT_W       = 11,
    parameter  int DEFAULT_DIV = 6,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              bigClk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              divLoad,
    input  logic [CH_W-1:0]   divCh,
    input  logic [CNT_W-1:0]  divVal,
    input  logic              divMode,
    output logic [NUM_CH-1:0] smallClk,
    output logic [NUM_CH-1:0] tick,
    output logic              divErr
);

    logic load_ok_s;
    logic div_err_d;
    logic div_err_q;

    // Validate the config strobe: divisor must be >= 2 and the channel must exist.
    always_comb begin
        div_err_d = 1'b0;
        load_ok_s = 1'b0;
        if (divLoad) begin
            if ((divVal < CNT_W'(2)) || ({1'b0, divCh} >= (CH_W + 1)'(NUM_CH))) begin
                div_err_d = 1'b1;
            end else begin
                load_ok_s = 1'b1;
            end
        end else begin
            div_err_d = 1'b0;
        end
    end

    // Rejection flag register.
    always_ff @(posedge bigClk or posedge rst) begin
        if (rst) begin
            div_err_q <= 1'b0;
        end else begin
            div_err_q <= div_err_d;
        end
    end

    assign divErr = div_err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] div_q, div_d;
        logic [CNT_W-1:0] pdiv_q, pdiv_d;
        logic [CNT_W-1:0] div_nx_s;
        logic [CNT_W-1:0] hi_s;
        logic             mode_q, mode_d;
        logic             pmode_q, pmode_d;
        logic             pend_q, pend_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;
        logic             mode_nx_s;
        logic             hit_s;

        // Next-state for one channel; div_nx/mode_nx are the settings a fresh period would use.
        always_comb begin
            hit_s     = load_ok_s && (divCh == CH_W'(g));
            div_nx_s  = div_q;
            mode_nx_s = mode_q;
            if (hit_s) begin
                div_nx_s  = divVal;
                mode_nx_s = divMode;
            end else if (pend_q) begin
                div_nx_s  = pdiv_q;
                mode_nx_s = pmode_q;
            end else begin
                div_nx_s  = div_q;
            end

            cnt_d   = cnt_q;
            div_d   = div_q;
            mode_d  = mode_q;
            pend_d  = pend_q;
            pdiv_d  = pdiv_q;
            pmode_d = pmode_q;

            if (!en[g]) begin
                div_d  = div_nx_s;
                mode_d = mode_nx_s;
                pend_d = 1'b0;
                cnt_d  = div_nx_s - CNT_W'(1);
            end else if (cnt_q == (div_q - CNT_W'(1))) begin
                // Period boundary: the whole new period runs on the committed settings.
                div_d  = div_nx_s;
                mode_d = mode_nx_s;
                pend_d = 1'b0;
                cnt_d  = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                if (hit_s) begin
                    pend_d  = 1'b1;
                    pdiv_d  = divVal;
                    pmode_d = divMode;
                end else begin
                    pend_d  = pend_q;
                end
            end

            hi_s   = mode_d ? CNT_W'(1) : (div_d - (div_d >> 1));
            clk_d  = en[g] && (cnt_d < hi_s);
            tick_d = en[g] && (cnt_d == {CNT_W{1'b0}});
        end

        // Channel state registers; reset leaves the channel idle at the default divisor.
        always_ff @(posedge bigClk or posedge rst) begin
            if (rst) begin
                cnt_q   <= CNT_W'(DEFAULT_DIV - 1);
                div_q   <= CNT_W'(DEFAULT_DIV);
                mode_q  <= 1'b0;
                pend_q  <= 1'b0;
                pdiv_q  <= CNT_W'(DEFAULT_DIV);
                pmode_q <= 1'b0;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                div_q   <= div_d;
                mode_q  <= mode_d;
                pend_q  <= pend_d;
                pdiv_q  <= pdiv_d;
                pmode_q <= pmode_d;
                clk_q   <= clk_d;
                tick_q  <= tick_d;
            end
        end

        assign smallClk[g] = clk_q;
        assign tick[g]     = tick_q;
    end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Self-checking bench for clk_divider_multi: a waveform-queue reference model is stepped
// every clock edge and compared against all outputs.
module tb_clk_divider_multi;

    localparam int NCH   = 3;
    localparam int CNT_W = 11;
    localparam int CH_W  = 2;
    localparam int DDIV  = 6;

    logic             bigClk = 1'b0;
    logic             rst    = 1'b0;
    logic [NCH-1:0]   en     = '0;
    logic             divLoad = 1'b0;
    logic [CH_W-1:0]  divCh  = '0;
    logic [CNT_W-1:0] divVal = '0;
    logic             divMode = 1'b0;
    logic [NCH-1:0]   smallClk;
    logic [NCH-1:0]   tick;
    logic             divErr;

    int checks = 0;
    int errors = 0;

    // reference model: each channel holds the remaining samples {tick,clk} of its current period
    logic [1:0]  wq [NCH][$];
    int unsigned m_div   [NCH];
    bit          m_mode  [NCH];
    bit          m_pv    [NCH];
    int unsigned m_pdiv  [NCH];
    bit          m_pmode [NCH];
    logic [NCH-1:0] exp_clk;
    logic [NCH-1:0] exp_tick;
    logic           exp_err;

    clk_divider_multi #(.NUM_CH(NCH), .CNT_W(CNT_W), .DEFAULT_DIV(DDIV)) dut (
        .bigClk(bigClk), .rst(rst), .en(en), .divLoad(divLoad), .divCh(divCh),
        .divVal(divVal), .divMode(divMode), .smallClk(smallClk), .tick(tick), .divErr(divErr)
    );

    always #5 bigClk = ~bigClk;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            wq[c].delete();
            m_div[c]  = DDIV;
            m_mode[c] = 1'b0;
            m_pv[c]   = 1'b0;
        end
        exp_clk  = '0;
        exp_tick = '0;
        exp_err  = 1'b0;
    endtask

    task automatic model_edge();
        bit ok;
        bit hit;
        int unsigned hi;
        logic [1:0] s;
        exp_err = divLoad && ((divVal < 2) || (int'(divCh) >= NCH));
        ok = divLoad && !exp_err;
        for (int c = 0; c < NCH; c++) begin
            hit = ok && (int'(divCh) == c);
            if (!en[c] || wq[c].size() == 0) begin
                if (hit) begin
                    m_div[c] = divVal; m_mode[c] = divMode;
                end else if (m_pv[c]) begin
                    m_div[c] = m_pdiv[c]; m_mode[c] = m_pmode[c];
                end
                m_pv[c] = 1'b0;
            end else if (hit) begin
                m_pv[c] = 1'b1; m_pdiv[c] = divVal; m_pmode[c] = divMode;
            end
            if (!en[c]) begin
                wq[c].delete();
                exp_clk[c]  = 1'b0;
                exp_tick[c] = 1'b0;
            end else begin
                if (wq[c].size() == 0) begin
                    hi = m_mode[c] ? 1 : (m_div[c] + 1) / 2;
                    for (int k = 0; k < int'(m_div[c]); k++)
                        wq[c].push_back({(k == 0), (k < int'(hi))});
                end
                s = wq[c].pop_front();
                exp_clk[c]  = s[0];
                exp_tick[c] = s[1];
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("smallClk", 32'(smallClk), 32'(exp_clk));
        check("tick", 32'(tick), 32'(exp_tick));
        check("divErr", 32'(divErr), 32'(exp_err));
    endtask

    task automatic cyc();
        @(posedge bigClk);
        if (rst) model_reset(); else model_edge();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic load(input int ch, input int val, input bit md);
        divLoad = 1'b1; divCh = CH_W'(ch); divVal = CNT_W'(val); divMode = md;
        cyc();
        divLoad = 1'b0;
    endtask

    initial begin
        bit found;
        model_reset();
        rst = 1'b1;
        #1;
        check("rst_async", {29'd0, smallClk, tick[0], divErr}, 32'd0);
        run(3);
        rst = 1'b0;
        check("rst_tick", 32'(tick), 32'd0);

        // channel 0 free-running at the default divisor
        en = 3'b001;
        run(20);

        // N=5 toggle loaded mid-period
        run(2);
        load(0, 5, 1'b0);
        run(20);

        // ch1 pulse N=4 while ch0 keeps its phase
        load(1, 4, 1'b1);
        en = 3'b011;
        run(16);

        // rejected loads: divisor too small, nonexistent channel
        load(0, 1, 1'b0);
        load(3, 7, 1'b0);
        run(12);

        // two loads within one period: last wins
        run(1);
        load(0, 8, 1'b0);
        load(0, 10, 1'b0);
        run(25);

        // en drop while high
        found = 1'b0;
        for (int i = 0; i < 24 && !found; i++) begin
            cyc();
            if (smallClk[0]) found = 1'b1;
        end
        check("wait_high", 32'(found), 32'd1);
        en[0] = 1'b0;
        cyc();
        check("en_drop_low", 32'(smallClk[0]), 32'd0);
        run(3);
        en[0] = 1'b1;
        run(12);

        // asynchronous reset mid-count
        run(3);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_mid", {29'd0, smallClk[0], tick[0], divErr}, 32'd0);
        check("rst_mid_clk", 32'(smallClk), 32'd0);
        run(2);
        rst = 1'b0;
        en = 3'b001;
        run(14);

        // randomized traffic
        en = 3'b111;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(15) == 0) en[$urandom_range(NCH - 1)] ^= 1'b1;
            if ($urandom_range(5) == 0) begin
                divLoad = 1'b1;
                divCh   = CH_W'($urandom_range(3));
                divVal  = CNT_W'($urandom_range(12));
                divMode = 1'($urandom_range(1));
            end else begin
                divLoad = 1'b0;
            end
            cyc();
        end
        divLoad = 1'b0;
        run(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
